// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the instruction fetch path
//
// Contents:
//   fetch_state_t    - fetch sequencer states
//   fetch_entry_t    - one fetched instruction together with its PC
//   DEF_RESET_VECTOR - default PC after reset
//   DEF_PC_STEP      - default sequential PC increment
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus: memory handshake, branch and decode sides
//
// Signals (direction seen from the master, i.e. the fetch controller):
//   BranchTaken, BranchAddr   in   redirect request and target
//   Stall                     in   decode cannot accept
//   MemAck, MemRData          in   memory response
//   MemReq, InstrAddr         out  memory request
//   InstrOut, InstrValid      out  instruction presented to decode
//   PCOut, PCAddrInc          out  PC of InstrOut and its link address
interface fetch_ctrl_if #(
   parameter int ADDR_W = 16
);

   logic              BranchTaken;
   logic [31:0]       BranchAddr;
   logic              Stall;
   logic              MemAck;
   logic [31:0]       MemRData;
   logic              MemReq;
   logic [ADDR_W-1:0] InstrAddr;
   logic [31:0]       InstrOut;
   logic              InstrValid;
   logic [31:0]       PCOut;
   logic [31:0]       PCAddrInc;

   modport master (
      input  BranchTaken, BranchAddr, Stall, MemAck, MemRData,
      output MemReq, InstrAddr, InstrOut, InstrValid, PCOut, PCAddrInc
   );

   modport slave (
      output BranchTaken, BranchAddr, Stall, MemAck, MemRData,
      input  MemReq, InstrAddr, InstrOut, InstrValid, PCOut, PCAddrInc
   );

endinterface

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry skid buffer for a fetched instruction
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          capture i_entry and mark full
//   i_unload        mark empty after the entry has been taken
//   i_flush         discard the entry (wins over load/unload)
//   i_entry         instruction + PC to capture
//   o_entry         stored instruction + PC
//   o_full          entry holds valid data
module fetch_skid
   import cpu_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic         i_unload,
   input  logic         i_flush,
   input  fetch_entry_t i_entry,
   output fetch_entry_t o_entry,
   output logic         o_full
);

   fetch_entry_t r_entry;
   logic         r_full;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_entry <= '0;
         r_full  <= 1'b0;
      end else if (i_flush) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_entry <= i_entry;
         r_full  <= 1'b1;
      end else if (i_unload) begin
         r_full <= 1'b0;
      end
   end

   assign o_entry = r_entry;
   assign o_full  = r_full;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch sequencer with PC, memory handshake and skid buffer
//
// Ports:
//   Clock   system clock, rising edge
//   nReset  asynchronous active-low reset
//   bus     fetch_ctrl_if.master: branch redirect, decode stall, memory
//           request/ack/data, and the instruction/PC presented to decode
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] PC_STEP      = DEF_PC_STEP,
   parameter int          ADDR_W       = 16
)(
   input  logic          Clock,
   input  logic          nReset,
   fetch_ctrl_if.master  bus
);

   fetch_state_t      r_state;
   fetch_state_t      w_next_state;
   logic              r_boot;
   logic [31:0]       r_fetch_pc;
   logic [31:0]       w_next_pc;
   logic [ADDR_W-1:0] r_instr_addr;
   logic              r_mem_req;
   logic [31:0]       r_instr;
   logic [31:0]       w_next_instr;
   logic [31:0]       r_pc_out;
   logic [31:0]       w_next_pc_out;
   logic              r_valid;
   logic              w_next_valid;

   logic              w_ack;
   logic              w_consume;
   logic              w_slot_free;
   logic              w_skid_load;
   logic              w_skid_unload;
   logic              w_skid_flush;
   logic              w_skid_full;
   fetch_entry_t      w_skid_in;
   fetch_entry_t      w_skid_out;

   // An ack only counts against a request we actually raised.
   assign w_ack       = bus.MemAck && r_mem_req;
   assign w_consume   = r_valid && !bus.Stall;
   assign w_slot_free = !r_valid || w_consume;
   assign w_skid_in   = fetch_entry_t'{instr: bus.MemRData, pc: r_fetch_pc};

   fetch_skid u_skid (
      .i_clk    (Clock),
      .i_rst_n  (nReset),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_flush  (w_skid_flush),
      .i_entry  (w_skid_in),
      .o_entry  (w_skid_out),
      .o_full   (w_skid_full)
   );

   always_comb begin
      w_next_state  = r_state;
      w_next_pc     = r_fetch_pc;
      w_next_instr  = r_instr;
      w_next_pc_out = r_pc_out;
      w_next_valid  = r_valid && !w_consume;
      w_skid_load   = 1'b0;
      w_skid_unload = 1'b0;
      w_skid_flush  = 1'b0;

      case (r_state)
         // r_boot is clear on the first edge after reset release, so IDLE
         // spans that edge and hands over to FETCH on the next one.
         IDLE: begin
            if (r_boot) begin
               w_next_state = FETCH;
            end
         end

         FETCH: begin
            if (bus.BranchTaken) begin
               w_next_pc    = bus.BranchAddr;
               w_next_valid = 1'b0;
               w_skid_flush = 1'b1;
               // Without an ack the wrong-path request is still in flight
               // and must be drained before fetching from the target.
               w_next_state = w_ack ? FETCH : DROP;
            end else if (w_ack) begin
               w_next_pc = r_fetch_pc + PC_STEP;
               if (w_slot_free) begin
                  w_next_instr  = bus.MemRData;
                  w_next_pc_out = r_fetch_pc;
                  w_next_valid  = 1'b1;
               end else begin
                  w_skid_load  = 1'b1;
                  w_next_state = HOLD;
               end
            end
         end

         HOLD: begin
            if (bus.BranchTaken) begin
               w_next_pc    = bus.BranchAddr;
               w_next_valid = 1'b0;
               w_skid_flush = 1'b1;
               w_next_state = FETCH;
            end else if (w_consume && w_skid_full) begin
               w_next_instr  = w_skid_out.instr;
               w_next_pc_out = w_skid_out.pc;
               w_next_valid  = 1'b1;
               w_skid_unload = 1'b1;
               w_next_state  = FETCH;
            end
         end

         DROP: begin
            if (bus.BranchTaken) begin
               w_next_pc    = bus.BranchAddr;
               w_next_valid = 1'b0;
               w_skid_flush = 1'b1;
            end else if (w_ack) begin
               w_next_state = FETCH;
            end
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state      <= IDLE;
         r_boot       <= 1'b0;
         r_fetch_pc   <= RESET_VECTOR;
         r_instr_addr <= RESET_VECTOR[ADDR_W-1:0];
         r_mem_req    <= 1'b0;
         r_instr      <= 32'h0;
         r_pc_out     <= 32'h0;
         r_valid      <= 1'b0;
      end else begin
         r_boot     <= 1'b1;
         r_state    <= w_next_state;
         r_fetch_pc <= w_next_pc;
         r_mem_req  <= (w_next_state == FETCH) || (w_next_state == DROP);
         // In DROP the old request is still outstanding, so its address is
         // held while FetchPC already points at the branch target.
         if (w_next_state != DROP) begin
            r_instr_addr <= w_next_pc[ADDR_W-1:0];
         end
         r_instr  <= w_next_instr;
         r_pc_out <= w_next_pc_out;
         r_valid  <= w_next_valid;
      end
   end

   assign bus.MemReq     = r_mem_req;
   assign bus.InstrAddr  = r_instr_addr;
   assign bus.InstrOut   = r_instr;
   assign bus.InstrValid = r_valid;
   assign bus.PCOut      = r_pc_out;
   assign bus.PCAddrInc  = r_pc_out + PC_STEP;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   logic Clock = 1'b0;
   logic nReset;

   always #5 Clock = ~Clock;

   fetch_ctrl_if #(.ADDR_W(16)) bus ();

   fetch_ctrl #(
      .RESET_VECTOR (32'h0000_0000),
      .PC_STEP      (32'd4),
      .ADDR_W       (16)
   ) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus)
   );

   int          n_checks   = 0;
   int          n_fail     = 0;
   int          n_consumed = 0;
   logic        mem_auto   = 1'b0;
   logic        man_ack    = 1'b0;
   logic        auto_ack   = 1'b0;
   int          wait_cnt   = 0;
   logic [31:0] exp_pc     = 32'h0;
   logic        mon_pending = 1'b0;
   logic [15:0] mon_addr   = 16'h0;

   // Memory returns its own address as the instruction word.
   assign bus.MemAck   = mem_auto ? auto_ack : man_ack;
   assign bus.MemRData = {16'h0000, bus.InstrAddr};

   // Random-latency memory (0..3 wait states per request)
   initial begin
      forever begin
         @(posedge Clock);
         #1;
         if (!nReset || !bus.MemReq) begin
            auto_ack = 1'b0;
         end else if (wait_cnt == 0) begin
            auto_ack = 1'b1;
            wait_cnt = $urandom_range(0, 3);
         end else begin
            auto_ack = 1'b0;
            wait_cnt--;
         end
      end
   end

   // Reference model: every consumed instruction follows the program order
   // (sequential +4, restarted at each branch target), and a raised request
   // keeps its address until acknowledged.
   initial begin
      forever begin
         @(negedge Clock);
         if (!nReset) begin
            exp_pc      = 32'h0;
            mon_pending = 1'b0;
         end else begin
            if (mon_pending) begin
               n_checks++;
               if (bus.MemReq !== 1'b1 || bus.InstrAddr !== mon_addr) begin
                  n_fail++;
                  $display("FAIL req_hold: MemReq=%0b InstrAddr=%h, required MemReq=1 InstrAddr=%h",
                           bus.MemReq, bus.InstrAddr, mon_addr);
               end
            end
            mon_pending = bus.MemReq && !bus.MemAck;
            mon_addr    = bus.InstrAddr;
            if (bus.InstrValid && !bus.Stall) begin
               n_checks++;
               n_consumed++;
               if (bus.PCOut !== exp_pc || bus.InstrOut !== {16'h0000, exp_pc[15:0]} ||
                   bus.PCAddrInc !== exp_pc + 32'd4) begin
                  n_fail++;
                  $display("FAIL consume_order: PCOut=%h InstrOut=%h PCAddrInc=%h, required PC=%h",
                           bus.PCOut, bus.InstrOut, bus.PCAddrInc, exp_pc);
               end
               exp_pc = exp_pc + 32'd4;
            end
            if (bus.BranchTaken) begin
               exp_pc = bus.BranchAddr;
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      nReset          = 1'b0;
      mem_auto        = 1'b0;
      man_ack         = 1'b0;
      bus.Stall       = 1'b0;
      bus.BranchTaken = 1'b0;
      bus.BranchAddr  = 32'h0;
      repeat (2) tick();
      nReset = 1'b1;
   endtask

   task automatic test_reset();
      nReset          = 1'b0;
      bus.Stall       = 1'b0;
      bus.BranchTaken = 1'b0;
      bus.BranchAddr  = 32'h0;
      tick();
      n_checks++;
      if ({bus.MemReq, bus.InstrValid, bus.InstrOut, bus.PCOut, bus.InstrAddr} !== 82'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%0b valid=%0b instr=%h pc=%h addr=%h, required all zero",
                  bus.MemReq, bus.InstrValid, bus.InstrOut, bus.PCOut, bus.InstrAddr);
      end
      n_checks++;
      if (bus.PCAddrInc !== 32'd4) begin
         n_fail++;
         $display("FAIL reset_pcinc: PCAddrInc=%h, required 00000004", bus.PCAddrInc);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] e;
      do_reset();
      man_ack = 1'b1;
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.MemReq} !== 2'b00) begin
         n_fail++;
         $display("FAIL seq_edge1: valid=%0b req=%0b, required 0 0", bus.InstrValid, bus.MemReq);
      end
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.MemReq, bus.InstrAddr} !== {1'b0, 1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL seq_edge2: valid=%0b req=%0b addr=%h, required 0 1 0000",
                  bus.InstrValid, bus.MemReq, bus.InstrAddr);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         e = 32'(i * 4);
         n_checks++;
         if ({bus.InstrValid, bus.InstrOut, bus.PCOut, bus.PCAddrInc} !== {1'b1, e, e, e + 32'd4}) begin
            n_fail++;
            $display("FAIL seq_stream[%0d]: valid=%0b instr=%h pc=%h inc=%h, required 1 %h %h %h",
                     i, bus.InstrValid, bus.InstrOut, bus.PCOut, bus.PCAddrInc, e, e, e + 32'd4);
         end
      end
      man_ack = 1'b0;
   endtask

   task automatic test_skid();
      do_reset();
      man_ack = 1'b1;
      repeat (3) tick();
      bus.Stall = 1'b1;
      tick();
      man_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({bus.MemReq, bus.InstrValid, bus.InstrOut, bus.PCOut} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL skid_hold[%0d]: req=%0b valid=%0b instr=%h pc=%h, required 0 1 0 0",
                     i, bus.MemReq, bus.InstrValid, bus.InstrOut, bus.PCOut);
         end
         tick();
      end
      bus.Stall = 1'b0;
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.InstrOut, bus.PCOut, bus.MemReq, bus.InstrAddr} !==
          {1'b1, 32'h4, 32'h4, 1'b1, 16'h0008}) begin
         n_fail++;
         $display("FAIL skid_unload: valid=%0b instr=%h pc=%h req=%0b addr=%h, required 1 4 4 1 0008",
                  bus.InstrValid, bus.InstrOut, bus.PCOut, bus.MemReq, bus.InstrAddr);
      end
   endtask

   task automatic test_branch_drop();
      bus.BranchTaken = 1'b1;
      bus.BranchAddr  = 32'h100;
      tick();
      bus.BranchTaken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({bus.InstrValid, bus.MemReq, bus.InstrAddr} !== {1'b0, 1'b1, 16'h0008}) begin
            n_fail++;
            $display("FAIL drop_wait[%0d]: valid=%0b req=%0b addr=%h, required 0 1 0008",
                     i, bus.InstrValid, bus.MemReq, bus.InstrAddr);
         end
         if (i == 2) man_ack = 1'b1;
         tick();
      end
      n_checks++;
      if ({bus.InstrValid, bus.InstrAddr} !== {1'b0, 16'h0100}) begin
         n_fail++;
         $display("FAIL drop_discard: valid=%0b addr=%h, required 0 0100", bus.InstrValid, bus.InstrAddr);
      end
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.InstrOut, bus.PCOut} !== {1'b1, 32'h100, 32'h100}) begin
         n_fail++;
         $display("FAIL drop_target: valid=%0b instr=%h pc=%h, required 1 100 100",
                  bus.InstrValid, bus.InstrOut, bus.PCOut);
      end
   endtask

   task automatic test_branch_skid();
      bus.Stall = 1'b1;
      tick();
      n_checks++;
      if ({bus.MemReq, bus.InstrOut} !== {1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL bskid_full: req=%0b instr=%h, required 0 100", bus.MemReq, bus.InstrOut);
      end
      bus.BranchTaken = 1'b1;
      bus.BranchAddr  = 32'h200;
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.MemReq, bus.InstrAddr} !== {1'b0, 1'b1, 16'h0200}) begin
         n_fail++;
         $display("FAIL bskid_flush: valid=%0b req=%0b addr=%h, required 0 1 0200",
                  bus.InstrValid, bus.MemReq, bus.InstrAddr);
      end
      bus.BranchTaken = 1'b0;
      bus.Stall       = 1'b0;
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.InstrOut, bus.PCOut} !== {1'b1, 32'h200, 32'h200}) begin
         n_fail++;
         $display("FAIL bskid_target: valid=%0b instr=%h pc=%h, required 1 200 200",
                  bus.InstrValid, bus.InstrOut, bus.PCOut);
      end
      bus.BranchTaken = 1'b1;
      bus.BranchAddr  = 32'h300;
      bus.Stall       = 1'b1;
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.InstrAddr} !== {1'b0, 16'h0300}) begin
         n_fail++;
         $display("FAIL back_to_back_ack_branch: valid=%0b addr=%h, required 0 0300",
                  bus.InstrValid, bus.InstrAddr);
      end
      bus.BranchTaken = 1'b0;
      bus.Stall       = 1'b0;
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.InstrOut, bus.PCOut} !== {1'b1, 32'h300, 32'h300}) begin
         n_fail++;
         $display("FAIL ack_branch_target: valid=%0b instr=%h pc=%h, required 1 300 300",
                  bus.InstrValid, bus.InstrOut, bus.PCOut);
      end
   endtask

   task automatic test_wrap();
      man_ack         = 1'b0;
      bus.BranchTaken = 1'b1;
      bus.BranchAddr  = 32'hFFFF_FFFC;
      tick();
      bus.BranchTaken = 1'b0;
      man_ack         = 1'b1;
      tick();
      n_checks++;
      if (bus.InstrAddr !== 16'hFFFC) begin
         n_fail++;
         $display("FAIL wrap_addr: InstrAddr=%h, required FFFC", bus.InstrAddr);
      end
      tick();
      n_checks++;
      if ({bus.PCOut, bus.InstrOut, bus.PCAddrInc, bus.InstrAddr} !==
          {32'hFFFF_FFFC, 32'h0000_FFFC, 32'h0, 16'h0000}) begin
         n_fail++;
         $display("FAIL wrap_last: pc=%h instr=%h inc=%h addr=%h, required FFFFFFFC 0000FFFC 0 0000",
                  bus.PCOut, bus.InstrOut, bus.PCAddrInc, bus.InstrAddr);
      end
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.PCOut, bus.InstrOut} !== {1'b1, 32'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL wrap_first: valid=%0b pc=%h instr=%h, required 1 0 0",
                  bus.InstrValid, bus.PCOut, bus.InstrOut);
      end
   endtask

   task automatic test_reset_mid_drop();
      man_ack         = 1'b0;
      bus.BranchTaken = 1'b1;
      bus.BranchAddr  = 32'h400;
      tick();
      bus.BranchTaken = 1'b0;
      tick();
      #2;
      nReset = 1'b0;
      #1;
      n_checks++;
      if ({bus.MemReq, bus.InstrValid, bus.InstrOut, bus.PCOut, bus.InstrAddr} !== 82'h0) begin
         n_fail++;
         $display("FAIL async_reset: req=%0b valid=%0b instr=%h pc=%h addr=%h, required all zero",
                  bus.MemReq, bus.InstrValid, bus.InstrOut, bus.PCOut, bus.InstrAddr);
      end
      repeat (2) tick();
      nReset  = 1'b1;
      man_ack = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (bus.InstrValid !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_latency: valid=%0b, required 0", bus.InstrValid);
      end
      tick();
      n_checks++;
      if ({bus.InstrValid, bus.InstrOut, bus.PCOut} !== {1'b1, 32'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL restart_vector: valid=%0b instr=%h pc=%h, required 1 0 0",
                  bus.InstrValid, bus.InstrOut, bus.PCOut);
      end
      man_ack = 1'b0;
   endtask

   task automatic test_random();
      int start;
      do_reset();
      mem_auto = 1'b1;
      repeat (3) tick();
      start = n_consumed;
      for (int i = 0; i < 1500; i++) begin
         bus.Stall       = ($urandom_range(0, 99) < 30);
         bus.BranchTaken = ($urandom_range(0, 99) < 4);
         bus.BranchAddr  = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      bus.Stall       = 1'b0;
      bus.BranchTaken = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (n_consumed - start <= 150) begin
         n_fail++;
         $display("FAIL random_progress: consumed=%0d, required more than 150", n_consumed - start);
      end
      mem_auto = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_skid();
      test_branch_drop();
      test_branch_skid();
      test_wrap();
      test_reset_mid_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
